// File: rtl/acc_mem_arb_pkg.sv
// Shared constants and FSM state encoding for the accelerator memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package acc_mem_arb_pkg;

  localparam int REQ_W_DEF  = 110;
  localparam int RESP_W_DEF = 65;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10,
    DELIVER   = 2'b11
  } arb_state_t;

endpackage

// File: rtl/acc_rr_pick.sv
// Two-way round-robin winner selection between engine request lines.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module acc_rr_pick (
  input  logic [1:0] reqs,
  input  logic       rr_ptr,
  output logic       valid,
  output logic       winner
);

  // Contention goes to the priority pointer; a lone requester always wins.
  always_comb begin
    valid  = |reqs;
    winner = 1'b0;
    if (reqs == 2'b11) begin
      winner = rr_ptr;
    end else begin
      winner = reqs[1];
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Arbitrates two engines onto one ACB memory port, one transaction in flight.
// Latency: request accept to response delivery 3 cycles; 4-cycle minimum spacing.
// Backpressure: losing/late engine sees write_ack low and keeps its request pending.
module acc_mem_arbiter
  import acc_mem_arb_pkg::*;
#(
  parameter int REQ_W  = REQ_W_DEF,
  parameter int RESP_W = RESP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ENG0_MEM_REQUEST_pipe_write_req,
  output logic              ENG0_MEM_REQUEST_pipe_write_ack,
  input  logic [REQ_W-1:0]  ENG0_MEM_REQUEST_pipe_write_data,
  input  logic              ENG1_MEM_REQUEST_pipe_write_req,
  output logic              ENG1_MEM_REQUEST_pipe_write_ack,
  input  logic [REQ_W-1:0]  ENG1_MEM_REQUEST_pipe_write_data,
  input  logic              ENG0_MEM_RESPONSE_pipe_read_req,
  output logic              ENG0_MEM_RESPONSE_pipe_read_ack,
  output logic [RESP_W-1:0] ENG0_MEM_RESPONSE_pipe_read_data,
  input  logic              ENG1_MEM_RESPONSE_pipe_read_req,
  output logic              ENG1_MEM_RESPONSE_pipe_read_ack,
  output logic [RESP_W-1:0] ENG1_MEM_RESPONSE_pipe_read_data,
  input  logic              ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic              ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  output logic [REQ_W-1:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic              ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic              ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
  input  logic [RESP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  output logic              busy,
  output logic              owner
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              rr_ptr;
  logic [REQ_W-1:0]  req_buf;
  logic [RESP_W-1:0] resp_buf;

  logic pick_vld;
  logic pick_win;
  logic grant;
  logic deliver_take;

  acc_rr_pick u_rr_pick (
    .reqs   ({ENG1_MEM_REQUEST_pipe_write_req, ENG0_MEM_REQUEST_pipe_write_req}),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .winner (pick_win)
  );

  // A grant is only offered while idle; reset masks it so no request is acked and then dropped.
  assign grant        = (state == IDLE) && pick_vld && !reset;
  assign deliver_take = owner ? ENG1_MEM_RESPONSE_pipe_read_req : ENG0_MEM_RESPONSE_pipe_read_req;

  // Next-state and handshake decode; apart from the idle grant, acks follow state and owner only.
  always_comb begin
    state_nxt                                  = state;
    ENG0_MEM_REQUEST_pipe_write_ack            = 1'b0;
    ENG1_MEM_REQUEST_pipe_write_ack            = 1'b0;
    ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = 1'b0;
    ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = '0;
    ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = 1'b0;
    ENG0_MEM_RESPONSE_pipe_read_ack            = 1'b0;
    ENG0_MEM_RESPONSE_pipe_read_data           = '0;
    ENG1_MEM_RESPONSE_pipe_read_ack            = 1'b0;
    ENG1_MEM_RESPONSE_pipe_read_data           = '0;
    busy                                       = (state != IDLE);
    case (state)
      IDLE: begin
        ENG0_MEM_REQUEST_pipe_write_ack = grant && !pick_win;
        ENG1_MEM_REQUEST_pipe_write_ack = grant && pick_win;
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = 1'b1;
        ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = req_buf;
        if (ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = 1'b1;
        if (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req) state_nxt = DELIVER;
      end
      DELIVER: begin
        if (owner) begin
          ENG1_MEM_RESPONSE_pipe_read_ack  = 1'b1;
          ENG1_MEM_RESPONSE_pipe_read_data = resp_buf;
        end else begin
          ENG0_MEM_RESPONSE_pipe_read_ack  = 1'b1;
          ENG0_MEM_RESPONSE_pipe_read_data = resp_buf;
        end
        if (deliver_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, ownership, priority pointer and the two data holding buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      req_buf  <= '0;
      resp_buf <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner   <= pick_win;
        req_buf <= pick_win ? ENG1_MEM_REQUEST_pipe_write_data : ENG0_MEM_REQUEST_pipe_write_data;
      end
      if ((state == WAIT_RESP) && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req) begin
        resp_buf <= ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
      end
      if ((state == DELIVER) && deliver_take) begin
        rr_ptr <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Self-checking bench for acc_mem_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a (simulation only).
// Backpressure: peers stall randomly or by script to exercise hold-off paths.
module tb_acc_mem_arbiter;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          e0_wreq = 1'b0, e1_wreq = 1'b0, e0_wack, e1_wack;
  logic [109:0]  e0_wdat = '0, e1_wdat = '0;
  logic          r0_rreq = 1'b0, r1_rreq = 1'b0, r0_rack, r1_rack;
  logic [64:0]   r0_rdat, r1_rdat;
  logic          a_rreq = 1'b0, a_rack;
  logic [109:0]  a_rdat;
  logic          m_wreq = 1'b0, m_wack;
  logic [64:0]   m_wdat = '0;
  logic          busy, owner;

  int total = 0;
  int bad = 0;

  // Transaction-level reference: at most one outstanding job and a fairness pointer.
  logic          m_have, m_sent, m_got, m_own, m_ptr;
  logic [109:0]  m_data;
  logic [64:0]   m_resp;
  logic [109:0]  q0[$], q1[$];
  int            g_eng[$], g_cyc[$], d_cyc[$];
  logic [64:0]   d0[$], d1[$];

  always #5 clk = ~clk;

  acc_mem_arbiter dut (
    .clk                                         (clk),
    .reset                                       (reset),
    .ENG0_MEM_REQUEST_pipe_write_req             (e0_wreq),
    .ENG0_MEM_REQUEST_pipe_write_ack             (e0_wack),
    .ENG0_MEM_REQUEST_pipe_write_data            (e0_wdat),
    .ENG1_MEM_REQUEST_pipe_write_req             (e1_wreq),
    .ENG1_MEM_REQUEST_pipe_write_ack             (e1_wack),
    .ENG1_MEM_REQUEST_pipe_write_data            (e1_wdat),
    .ENG0_MEM_RESPONSE_pipe_read_req             (r0_rreq),
    .ENG0_MEM_RESPONSE_pipe_read_ack             (r0_rack),
    .ENG0_MEM_RESPONSE_pipe_read_data            (r0_rdat),
    .ENG1_MEM_RESPONSE_pipe_read_req             (r1_rreq),
    .ENG1_MEM_RESPONSE_pipe_read_ack             (r1_rack),
    .ENG1_MEM_RESPONSE_pipe_read_data            (r1_rdat),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   (a_rreq),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   (a_rack),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  (a_rdat),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req (m_wreq),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack (m_wack),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(m_wdat),
    .busy                                        (busy),
    .owner                                       (owner)
  );

  // Memory behaviour: the response is a fixed scramble of the request word.
  function automatic logic [64:0] resp_of(input logic [109:0] d);
    return {d[109] ^ d[0], d[63:0] ^ 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  function automatic logic [109:0] rnd_req();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[109:0];
  endfunction

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    e0_wreq = 0; e1_wreq = 0; r0_rreq = 0; r1_rreq = 0; a_rreq = 0; m_wreq = 0;
    e0_wdat = '0; e1_wdat = '0; m_wdat = '0;
  endtask

  task automatic model_clear();
    m_have = 0; m_sent = 0; m_got = 0; m_own = 0; m_ptr = 0;
    m_data = '0; m_resp = '0;
    q0.delete(); q1.delete(); g_eng.delete(); g_cyc.delete(); d_cyc.delete();
    d0.delete(); d1.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%0b exp=0", owner); end
    total++; if ({e0_wack, e1_wack, a_rack, m_wack, r0_rack, r1_rack} !== 6'b0) begin
      bad++; $display("FAIL reset_acks got=%b exp=000000", {e0_wack, e1_wack, a_rack, m_wack, r0_rack, r1_rack});
    end
    total++; if (a_rdat !== '0) begin bad++; $display("FAIL reset_acb_data got=%0h exp=0", a_rdat); end
    total++; if (r0_rdat !== '0 || r1_rdat !== '0) begin
      bad++; $display("FAIL reset_resp_data got=%0h/%0h exp=0/0", r0_rdat, r1_rdat);
    end
    to_next();
  endtask

  task automatic test_single_eng0();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      e0_wreq = (k == 0); e0_wdat = 110'h1234; e1_wreq = 0;
      a_rreq = 1; m_wreq = 1; m_wdat = 65'h0_DEADBEEF; r0_rreq = 1; r1_rreq = 1;
      @(negedge clk);
      total++; if (e0_wack !== (k == 0)) begin bad++; $display("FAIL single_e0_wack k=%0d got=%0b", k, e0_wack); end
      total++; if (a_rack !== (k == 1)) begin bad++; $display("FAIL single_acb_ack k=%0d got=%0b", k, a_rack); end
      if (k == 1) begin
        total++; if (a_rdat !== 110'h1234) begin bad++; $display("FAIL single_acb_data got=%0h exp=1234", a_rdat); end
      end
      total++; if (m_wack !== (k == 2)) begin bad++; $display("FAIL single_mem_ack k=%0d got=%0b", k, m_wack); end
      total++; if (r0_rack !== (k == 3)) begin bad++; $display("FAIL single_r0_ack k=%0d got=%0b", k, r0_rack); end
      if (k == 3) begin
        total++; if (r0_rdat !== 65'h0_DEADBEEF) begin bad++; $display("FAIL single_r0_data got=%0h exp=deadbeef", r0_rdat); end
      end
      total++; if ({e1_wack, r1_rack} !== 2'b00 || r1_rdat !== '0) begin
        bad++; $display("FAIL single_eng1_quiet k=%0d acks=%b data=%0h exp 0", k, {e1_wack, r1_rack}, r1_rdat);
      end
      total++; if (busy !== (k >= 1 && k <= 3)) begin bad++; $display("FAIL single_busy k=%0d got=%0b", k, busy); end
      to_next();
    end
    idle_inputs();
  endtask

  // Drives queued engine requests with randomly ready peers, checking every cycle against the model.
  task automatic run_traffic(input int max_cyc, input int pa, input int pm, input int pr);
    int cyc;
    logic any, win;
    logic [5:0] exp_acks, got_acks;
    cyc = 0;
    while (cyc < max_cyc && (q0.size() > 0 || q1.size() > 0 || m_have)) begin
      e0_wreq = (q0.size() > 0); e0_wdat = e0_wreq ? q0[0] : '0;
      e1_wreq = (q1.size() > 0); e1_wdat = e1_wreq ? q1[0] : '0;
      a_rreq  = ($urandom_range(99) < pa);
      m_wreq  = ($urandom_range(99) < pm);
      m_wdat  = resp_of(m_data);
      r0_rreq = ($urandom_range(99) < pr);
      r1_rreq = ($urandom_range(99) < pr);
      @(negedge clk);
      any = e0_wreq | e1_wreq;
      win = (e0_wreq && e1_wreq) ? m_ptr : e1_wreq;
      exp_acks = {!m_have && any && !win, !m_have && any && win, m_have && !m_sent,
                  m_have && m_sent && !m_got, m_have && m_got && !m_own, m_have && m_got && m_own};
      got_acks = {e0_wack, e1_wack, a_rack, m_wack, r0_rack, r1_rack};
      total++; if (got_acks !== exp_acks) begin
        bad++; $display("FAIL traffic_acks cyc=%0d got=%b exp=%b", cyc, got_acks, exp_acks);
      end
      total++; if (busy !== m_have) begin bad++; $display("FAIL traffic_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_have); end
      total++; if (owner !== m_own) begin bad++; $display("FAIL traffic_owner cyc=%0d got=%0b exp=%0b", cyc, owner, m_own); end
      if (exp_acks[3]) begin
        total++; if (a_rdat !== m_data) begin bad++; $display("FAIL traffic_acb_data cyc=%0d got=%0h exp=%0h", cyc, a_rdat, m_data); end
      end
      if (exp_acks[1] || exp_acks[0]) begin
        total++; if ((m_own ? r1_rdat : r0_rdat) !== m_resp) begin
          bad++; $display("FAIL traffic_resp_data cyc=%0d got=%0h exp=%0h", cyc, m_own ? r1_rdat : r0_rdat, m_resp);
        end
      end
      total++; if ((m_own ? r0_rdat : r1_rdat) !== '0) begin
        bad++; $display("FAIL traffic_nonowner_data cyc=%0d got=%0h exp=0", cyc, m_own ? r0_rdat : r1_rdat);
      end
      if (exp_acks[5] && e0_wreq) begin
        m_have = 1; m_sent = 0; m_got = 0; m_own = 0; m_data = q0.pop_front();
        g_eng.push_back(0); g_cyc.push_back(cyc);
      end else if (exp_acks[4] && e1_wreq) begin
        m_have = 1; m_sent = 0; m_got = 0; m_own = 1; m_data = q1.pop_front();
        g_eng.push_back(1); g_cyc.push_back(cyc);
      end else if (exp_acks[3] && a_rreq) begin
        m_sent = 1;
      end else if (exp_acks[2] && m_wreq) begin
        m_got = 1; m_resp = m_wdat;
      end else if ((exp_acks[1] && r0_rreq) || (exp_acks[0] && r1_rreq)) begin
        if (m_own) d1.push_back(m_resp); else d0.push_back(m_resp);
        d_cyc.push_back(cyc);
        m_have = 0; m_ptr = ~m_own;
      end
      to_next();
      cyc++;
    end
    total++; if (q0.size() > 0 || q1.size() > 0 || m_have) begin
      bad++; $display("FAIL traffic_timeout pending=%0d/%0d inflight=%0b exp none", q0.size(), q1.size(), m_have);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [109:0] a, b;
    do_reset();
    a = rnd_req(); b = rnd_req();
    q0.push_back(a); q1.push_back(b);
    run_traffic(40, 100, 100, 100);
    total++; if (g_eng.size() != 2 || g_eng[0] != 0 || g_eng[1] != 1) begin
      bad++; $display("FAIL simul_order got=%0d grants first=%0d exp 2 grants 0 then 1", g_eng.size(), g_eng.size() > 0 ? g_eng[0] : -1);
    end
    total++; if (d1.size() != 1 || d1[0] !== resp_of(b)) begin
      bad++; $display("FAIL simul_eng1_resp count=%0d exp 1 with %0h", d1.size(), resp_of(b));
    end
    total++; if (d0.size() != 1 || d0[0] !== resp_of(a)) begin
      bad++; $display("FAIL simul_eng0_resp count=%0d exp 1 with %0h", d0.size(), resp_of(a));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin q0.push_back(rnd_req()); q1.push_back(rnd_req()); end
    run_traffic(100, 100, 100, 100);
    total++; if (g_eng.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", g_eng.size()); end
    for (int i = 0; i < g_eng.size(); i++) begin
      total++; if (g_eng[i] != i % 2) begin bad++; $display("FAIL b2b_grant i=%0d got=%0d exp=%0d", i, g_eng[i], i % 2); end
      if (i > 0) begin
        total++; if (g_cyc[i] - g_cyc[i-1] != 4) begin
          bad++; $display("FAIL b2b_spacing i=%0d got=%0d exp=4", i, g_cyc[i] - g_cyc[i-1]);
        end
      end
      if (i < d_cyc.size()) begin
        total++; if (d_cyc[i] - g_cyc[i] != 3) begin
          bad++; $display("FAIL b2b_latency i=%0d got=%0d exp=3", i, d_cyc[i] - g_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_acb_stall();
    logic [109:0] x;
    do_reset();
    x = rnd_req();
    for (int k = 0; k < 10; k++) begin
      e0_wreq = (k == 0); e0_wdat = x;
      a_rreq = (k == 6); m_wreq = (k == 7); m_wdat = resp_of(x); r0_rreq = (k == 8);
      @(negedge clk);
      if (k == 0) begin
        total++; if (e0_wack !== 1'b1) begin bad++; $display("FAIL stall_accept got=%0b exp=1", e0_wack); end
      end else if (k <= 6) begin
        total++; if (a_rack !== 1'b1 || a_rdat !== x) begin
          bad++; $display("FAIL stall_issue k=%0d ack=%0b data=%0h exp ack 1 data %0h", k, a_rack, a_rdat, x);
        end
        total++; if (m_wack !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL stall_hold k=%0d mack=%0b busy=%0b exp 0/1", k, m_wack, busy);
        end
      end else if (k == 7) begin
        total++; if (m_wack !== 1'b1 || a_rack !== 1'b0) begin
          bad++; $display("FAIL stall_wait mack=%0b aack=%0b exp 1/0", m_wack, a_rack);
        end
      end else if (k == 8) begin
        total++; if (r0_rack !== 1'b1 || r0_rdat !== resp_of(x)) begin
          bad++; $display("FAIL stall_deliver ack=%0b data=%0h exp 1/%0h", r0_rack, r0_rdat, resp_of(x));
        end
      end else begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_done busy=%0b exp=0", busy); end
      end
      to_next();
    end
    idle_inputs();
  endtask

  task automatic test_deliver_stall();
    logic [109:0] y, z;
    do_reset();
    y = rnd_req(); z = rnd_req();
    for (int k = 0; k < 12; k++) begin
      e0_wreq = (k == 0); e0_wdat = y;
      e1_wreq = (k >= 1 && k <= 7); e1_wdat = z;
      a_rreq = 1; m_wreq = 1; m_wdat = (k < 8) ? resp_of(y) : resp_of(z);
      r0_rreq = (k == 6); r1_rreq = (k >= 10);
      @(negedge clk);
      if (k == 0) begin
        total++; if (e0_wack !== 1'b1) begin bad++; $display("FAIL dstall_accept got=%0b exp=1", e0_wack); end
      end else if (k <= 6) begin
        total++; if (e1_wack !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL dstall_holdoff k=%0d e1ack=%0b busy=%0b exp 0/1", k, e1_wack, busy);
        end
        if (k >= 3) begin
          total++; if (r0_rack !== 1'b1 || r0_rdat !== resp_of(y)) begin
            bad++; $display("FAIL dstall_deliver k=%0d ack=%0b data=%0h exp 1/%0h", k, r0_rack, r0_rdat, resp_of(y));
          end
        end
      end else if (k == 7) begin
        total++; if (e1_wack !== 1'b1 || busy !== 1'b0) begin
          bad++; $display("FAIL dstall_late_grant e1ack=%0b busy=%0b exp 1/0", e1_wack, busy);
        end
      end else if (k == 8) begin
        total++; if (a_rack !== 1'b1 || a_rdat !== z || owner !== 1'b1) begin
          bad++; $display("FAIL dstall_e1_issue ack=%0b data=%0h owner=%0b exp 1/%0h/1", a_rack, a_rdat, owner, z);
        end
      end else if (k == 10) begin
        total++; if (r1_rack !== 1'b1 || r1_rdat !== resp_of(z) || r0_rack !== 1'b0) begin
          bad++; $display("FAIL dstall_e1_resp ack=%0b data=%0h exp 1/%0h", r1_rack, r1_rdat, resp_of(z));
        end
      end
      to_next();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [109:0] w;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      e0_wreq = (k == 0); e0_wdat = rnd_req(); a_rreq = 1; m_wreq = 0;
      @(negedge clk);
      if (k == 2) begin
        total++; if (m_wack !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL rmid_in_wait mack=%0b busy=%0b exp 1/1", m_wack, busy);
        end
      end
      to_next();
    end
    reset = 1;
    to_next();
    reset = 0;
    a_rreq = 1; m_wreq = 1; m_wdat = 65'h1_2345_6789; r0_rreq = 1; r1_rreq = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({e0_wack, e1_wack, a_rack, m_wack, r0_rack, r1_rack, busy, owner} !== 8'b0) begin
        bad++; $display("FAIL rmid_quiet k=%0d acks_busy_owner=%b exp 00000000", k,
                        {e0_wack, e1_wack, a_rack, m_wack, r0_rack, r1_rack, busy, owner});
      end
      to_next();
    end
    idle_inputs();
    model_clear();
    w = rnd_req();
    q1.push_back(w);
    run_traffic(40, 100, 100, 100);
    total++; if (d1.size() != 1 || d1[0] !== resp_of(w) || d0.size() != 0) begin
      bad++; $display("FAIL rmid_eng1_served got=%0d/%0d responses exp 0/1 with %0h", d0.size(), d1.size(), resp_of(w));
    end
  endtask

  task automatic test_random();
    logic [109:0] o0[$], o1[$];
    do_reset();
    for (int i = 0; i < 12; i++) begin
      o0.push_back(rnd_req()); o1.push_back(rnd_req());
    end
    q0 = o0; q1 = o1;
    run_traffic(3000, $urandom_range(90, 30), $urandom_range(90, 30), $urandom_range(90, 30));
    total++; if (d0.size() != 12 || d1.size() != 12) begin
      bad++; $display("FAIL random_count got=%0d/%0d exp=12/12", d0.size(), d1.size());
    end
    for (int i = 0; i < d0.size() && i < 12; i++) begin
      total++; if (d0[i] !== resp_of(o0[i])) begin bad++; $display("FAIL random_e0_order i=%0d got=%0h exp=%0h", i, d0[i], resp_of(o0[i])); end
    end
    for (int i = 0; i < d1.size() && i < 12; i++) begin
      total++; if (d1[i] !== resp_of(o1[i])) begin bad++; $display("FAIL random_e1_order i=%0d got=%0h exp=%0h", i, d1[i], resp_of(o1[i])); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_eng0();
    test_simultaneous();
    test_back_to_back();
    test_acb_stall();
    test_deliver_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_mem_arbiter.md
ACC_MEM_ARBITER -- requirements
Module: acc_mem_arbiter

Interface
REQ-001 Parameter REQ_W, default 110, SHALL set the ACB memory-request word width.
REQ-002 Parameter RESP_W, default 65, SHALL set the ACB memory-response word width.
REQ-003 clk  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ENG0_MEM_REQUEST_pipe_write_req / _write_ack / _write_data  in/out/in  1/1/REQ_W  engine-0 request write pipe.
REQ-006 ENG1_MEM_REQUEST_pipe_write_req / _write_ack / _write_data  in/out/in  1/1/REQ_W  engine-1 request write pipe.
REQ-007 ENG0_MEM_RESPONSE_pipe_read_req / _read_ack / _read_data  in/out/out  1/1/RESP_W  engine-0 response read pipe.
REQ-008 ENG1_MEM_RESPONSE_pipe_read_req / _read_ack / _read_data  in/out/out  1/1/RESP_W  engine-1 response read pipe.
REQ-009 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req / _read_ack / _read_data  in/out/out  1/1/REQ_W  shared memory request pipe.
REQ-010 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req / _write_ack / _write_data  in/out/in  1/1/RESP_W  shared memory response pipe.
REQ-011 busy  out  1  high whenever a transaction is in flight (state != IDLE).
REQ-012 owner  out  1  index of the engine owning the current transaction.

Function
REQ-013 A pipe transfer SHALL occur only in a cycle where its req and ack are both high; data SHALL be valid whenever ack is high.
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RESP, DELIVER; exactly one transaction in flight at any time.
REQ-015 IDLE: winner = engine with write_req high; both high -> engine indicated by priority pointer rr_ptr; winner's write_ack SHALL be high in that same cycle; data captured into req_buf, owner <= winner, -> ISSUE.
REQ-016 IDLE with no write_req SHALL remain in IDLE with all acks low.
REQ-017 ISSUE: ACB request read_ack = 1, read_data = req_buf; on ACB read_req -> WAIT_RESP.
REQ-018 WAIT_RESP: ACB response write_ack = 1; on ACB write_req, capture write_data into resp_buf -> DELIVER.
REQ-019 DELIVER: ENG[owner] response read_ack = 1, read_data = resp_buf; on that engine's read_req -> IDLE, rr_ptr <= ~owner.
REQ-020 Non-owner engine response read_ack SHALL be 0 in every state; its read_data SHALL be 0.
REQ-021 Only the IDLE-state write_ack SHALL depend combinationally on inputs; all other acks SHALL decode from state and owner only.
REQ-022 A write_req from the non-owner during a transaction SHALL be held off (ack low) and SHALL NOT be lost; it competes at the next IDLE.
REQ-023 Minimum latency with all counterparts always ready: request accept to response delivery = 3 cycles, back-to-back transactions every 4 cycles.
REQ-024 Round-robin SHALL guarantee that, with both engines continuously requesting, grants alternate 0,1,0,1...
REQ-025 Request and response words SHALL pass bit-exact; the block SHALL NOT interpret any field.

Reset
REQ-026 On reset: state = IDLE, rr_ptr = 0, owner = 0, req_buf = 0, resp_buf = 0; all acks, read_data, busy = 0 in the following cycle.
REQ-027 Reset asserted mid-transaction SHALL abandon it silently: no response delivered, no further ACB handshakes.

Structure
REQ-028 Package acc_mem_arb_pkg SHALL hold REQ_W/RESP_W defaults and the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT_RESP=2'b10, DELIVER=2'b11).
REQ-029 One sub-module acc_rr_pick SHALL implement the 2-way round-robin winner selection (combinational: reqs, rr_ptr -> valid, winner).

Verification
REQ-030 Only ENG0 requests data 110'h1234; memory ready -> ACB read_data = 110'h1234, ENG0 receives response 65'h0_DEADBEEF, ENG1 acks stay 0.
REQ-031 ENG0 and ENG1 request simultaneously after reset -> ENG0 granted first (rr_ptr=0), ENG1 granted in the next IDLE; ENG1 receives its own response.
REQ-032 Both engines request continuously for 8 transactions -> grant sequence 0,1,0,1,0,1,0,1; transaction spacing 4 cycles with all peers always ready.
REQ-033 ACB read_req held low 5 cycles in ISSUE -> state stays ISSUE, read_ack held 1, read_data stable; transfer on the 6th cycle.
REQ-034 Engine response read_req withheld 3 cycles in DELIVER -> new requests not acked until delivery completes; busy = 1 throughout.
REQ-035 Reset asserted in WAIT_RESP -> next cycle state IDLE, busy 0, all acks 0; a subsequent ENG1 request served normally.
